// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: operation codes, FSM states,
// byte-enable constants and lane helpers.
package lsu_pkg;

    typedef enum logic [2:0] {
        OP_LW   = 3'd0,
        OP_LH   = 3'd1,
        OP_LB   = 3'd2,
        OP_LBU  = 3'd3,
        OP_SW   = 3'd4,
        OP_SH   = 3'd5,
        OP_SB   = 3'd6,
        OP_RSVD = 3'd7
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE    = 4'b0001;

    function automatic logic is_store(mem_op_e op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    // Low address bits below the access size are ignored, giving natural alignment.
    function automatic logic [3:0] byte_enable(mem_op_e op, logic [1:0] lane);
        case (op)
            OP_LW, OP_SW:         return BE_WORD;
            OP_LH, OP_SH:         return lane[1] ? BE_HALF_HI : BE_HALF_LO;
            OP_LB, OP_LBU, OP_SB: return BE_BYTE << lane;
            default:              return BE_NONE;
        endcase
    endfunction

    function automatic logic [31:0] store_data(mem_op_e op, logic [31:0] data);
        case (op)
            OP_SB:   return {4{data[7:0]}};
            OP_SH:   return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic misaligned(mem_op_e op, logic [1:0] lane);
        case (op)
            OP_LW, OP_SW: return lane != 2'b00;
            OP_LH, OP_SH: return lane[0];
            default:      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half lane of a loaded word and sign- or
// zero-extends it to 32 bits; non-load ops yield zero.
module load_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] word_i,
    output logic [31:0] data_o
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        byteSel = word_i[7:0];
        case (lane_i)
            2'd0:    byteSel = word_i[7:0];
            2'd1:    byteSel = word_i[15:8];
            2'd2:    byteSel = word_i[23:16];
            default: byteSel = word_i[31:24];
        endcase
        halfSel = lane_i[1] ? word_i[31:16] : word_i[15:0];

        data_o = '0;
        case (mem_op_e'(op_i))
            OP_LW:   data_o = word_i;
            OP_LH:   data_o = {{16{halfSel[15]}}, halfSel};
            OP_LB:   data_o = {{24{byteSel[7]}}, byteSel};
            OP_LBU:  data_o = {24'd0, byteSel};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the EX stage and data memory.
// Define LSU_MISALIGN_TRAP_EN to suppress misaligned word/half accesses instead of truncating.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            mem_op,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [4:0]            rd_in,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [4:0]            rsp_rd,
    output logic                  rsp_misaligned,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [3:0]            dmem_be,
    output logic [DATA_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_gnt,
    input  logic                  dmem_rvalid,
    input  logic [DATA_WIDTH-1:0] dmem_rdata
);

    lsu_state_e            state_q, state_d;
    mem_op_e               op_q, op_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [4:0]            rd_q, rd_d;
    logic [DATA_WIDTH-1:0] rword_q, rword_d;
    logic                  mis_q, mis_d;
    logic                  reqMisaligned;
    logic                  inReq, inResp;
    logic [DATA_WIDTH-1:0] loadData;

`ifdef LSU_MISALIGN_TRAP_EN
    assign reqMisaligned = misaligned(mem_op_e'(mem_op), addr[1:0]);
`else
    assign reqMisaligned = 1'b0;
`endif

    // Misaligned and reserved requests skip memory and respond the next cycle.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        rword_d = rword_q;
        mis_d   = mis_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d    = mem_op_e'(mem_op);
                    addr_d  = addr;
                    wdata_d = wdata;
                    rd_d    = rd_in;
                    rword_d = '0;
                    mis_d   = reqMisaligned;
                    if (reqMisaligned || mem_op_e'(mem_op) == OP_RSVD) state_d = ST_RESP;
                    else                                               state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (dmem_gnt) state_d = is_store(op_q) ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                if (dmem_rvalid) begin
                    rword_d = dmem_rdata;
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LW;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            rword_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            rword_q <= rword_d;
            mis_q   <= mis_d;
        end
    end

    load_extend u_load_extend (
        .op_i   (op_q),
        .lane_i (addr_q[1:0]),
        .word_i (rword_q),
        .data_o (loadData)
    );

    // Outputs are decoded from registered state only, so reset clears them immediately.
    assign inReq          = (state_q == ST_REQ);
    assign inResp         = (state_q == ST_RESP);
    assign req_ready      = (state_q == ST_IDLE);
    assign dmem_req       = inReq;
    assign dmem_we        = inReq && is_store(op_q);
    assign dmem_be        = inReq ? byte_enable(op_q, addr_q[1:0]) : BE_NONE;
    assign dmem_addr      = inReq ? {addr_q[DATA_WIDTH-1:2], 2'b00} : '0;
    assign dmem_wdata     = (inReq && is_store(op_q)) ? store_data(op_q, wdata_q) : '0;
    assign rsp_valid      = inResp;
    assign rsp_rdata      = inResp ? loadData : '0;
    assign rsp_rd         = inResp ? rd_q : '0;
    assign rsp_misaligned = inResp && mis_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit: handshake, lanes,
// extension, stalls, reserved op and mid-transaction reset.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  mem_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd_in;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_rd;
    logic        rsp_misaligned;
    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    int checksTotal  = 0;
    int checksPassed = 0;
    int checksFailed = 0;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_WIDTH(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .mem_op         (mem_op),
        .addr           (addr),
        .wdata          (wdata),
        .rd_in          (rd_in),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_rd         (rsp_rd),
        .rsp_misaligned (rsp_misaligned),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_be        (dmem_be),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_gnt       (dmem_gnt),
        .dmem_rvalid    (dmem_rvalid),
        .dmem_rdata     (dmem_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checksTotal++;
        assert (observed === expected) checksPassed++;
        else begin
            checksFailed++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] w, input logic [4:0] rd);
        req_valid = 1'b1;
        mem_op    = op;
        addr      = a;
        wdata     = w;
        rd_in     = rd;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        req_valid   = 1'b0;
        mem_op      = 3'd0;
        addr        = '0;
        wdata       = '0;
        rd_in       = '0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;

        // Reset state
        #1 reset = 1'b0;
        #1;
        checkOutput("rst_ready", req_ready, 1);
        checkOutput("rst_dmem_req", dmem_req, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_dmem_be", dmem_be, 0);
        tick();
        tick();
        reset = 1'b1;

        // SW 0x100, immediate grant: request at N+1, response at N+2
        applyStimulus(OP_SW, 32'h100, 32'hDEADBEEF, 5'd3);
        dmem_gnt = 1'b1;
        checkOutput("sw_accept_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        checkOutput("sw_req", dmem_req, 1);
        checkOutput("sw_we", dmem_we, 1);
        checkOutput("sw_be", dmem_be, 4'b1111);
        checkOutput("sw_addr", dmem_addr, 32'h100);
        checkOutput("sw_wdata", dmem_wdata, 32'hDEADBEEF);
        checkOutput("sw_busy_ready", req_ready, 0);
        checkOutput("sw_no_early_rsp", rsp_valid, 0);
        tick();
        checkOutput("sw_rsp_valid", rsp_valid, 1);
        checkOutput("sw_rsp_rdata", rsp_rdata, 0);
        checkOutput("sw_rsp_req_low", dmem_req, 0);
        tick();
        checkOutput("sw_idle_ready", req_ready, 1);
        checkOutput("sw_rsp_pulse", rsp_valid, 0);

        // LB 0x103 with rvalid held early: rvalid in REQ must be ignored
        applyStimulus(OP_LB, 32'h103, 32'h0, 5'd7);
        dmem_gnt    = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h80FF1234;
        tick();
        req_valid = 1'b0;
        checkOutput("lb_be", dmem_be, 4'b1000);
        checkOutput("lb_we", dmem_we, 0);
        checkOutput("lb_addr", dmem_addr, 32'h100);
        tick();
        checkOutput("lb_wait_no_rsp", rsp_valid, 0);
        tick();
        checkOutput("lb_rsp_valid", rsp_valid, 1);
        checkOutput("lb_rdata", rsp_rdata, 32'hFFFFFF80);
        checkOutput("lb_rd", rsp_rd, 5'd7);
        tick();

        // LBU same access zero-extends
        applyStimulus(OP_LBU, 32'h103, 32'h0, 5'd8);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        checkOutput("lbu_rsp_valid", rsp_valid, 1);
        checkOutput("lbu_rdata", rsp_rdata, 32'h00000080);
        tick();
        dmem_rvalid = 1'b0;

        // SH 0x102 uses the upper half and replicates store data
        applyStimulus(OP_SH, 32'h102, 32'h0000ABCD, 5'd0);
        tick();
        req_valid = 1'b0;
        checkOutput("sh_be", dmem_be, 4'b1100);
        checkOutput("sh_wdata", dmem_wdata, 32'hABCDABCD);
        checkOutput("sh_we", dmem_we, 1);
        tick();
        checkOutput("sh_rsp_valid", rsp_valid, 1);
        tick();

        // LW 0x101: trapped when the misalign macro is set, truncated otherwise
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h12345678;
        applyStimulus(OP_LW, 32'h101, 32'h0, 5'd4);
        tick();
        req_valid = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        checkOutput("lw_mis_rsp_valid", rsp_valid, 1);
        checkOutput("lw_mis_flag", rsp_misaligned, 1);
        checkOutput("lw_mis_no_req", dmem_req, 0);
        checkOutput("lw_mis_rdata", rsp_rdata, 0);
        tick();
`else
        checkOutput("lw_trunc_req", dmem_req, 1);
        checkOutput("lw_trunc_addr", dmem_addr, 32'h100);
        checkOutput("lw_trunc_be", dmem_be, 4'b1111);
        tick();
        tick();
        checkOutput("lw_trunc_rsp_valid", rsp_valid, 1);
        checkOutput("lw_trunc_rdata", rsp_rdata, 32'h12345678);
        checkOutput("lw_trunc_mis", rsp_misaligned, 0);
        tick();
`endif
        dmem_rvalid = 1'b0;

        // LH 0x106 with grant delayed 3 cycles and req_valid held high
        dmem_gnt = 1'b0;
        applyStimulus(OP_LH, 32'h106, 32'h0, 5'd9);
        tick();
        addr = 32'h200;
        for (int i = 0; i < 3; i++) begin
            checkOutput("lh_stall_req", dmem_req, 1);
            checkOutput("lh_stall_addr", dmem_addr, 32'h104);
            checkOutput("lh_stall_be", dmem_be, 4'b1100);
            checkOutput("lh_stall_ready", req_ready, 0);
            checkOutput("lh_stall_no_rsp", rsp_valid, 0);
            tick();
        end
        dmem_gnt = 1'b1;
        checkOutput("lh_gnt_req", dmem_req, 1);
        tick();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h80017FFF;
        checkOutput("lh_wait_no_req", dmem_req, 0);
        checkOutput("lh_wait_no_rsp", rsp_valid, 0);
        tick();
        checkOutput("lh_rsp_valid", rsp_valid, 1);
        checkOutput("lh_rdata", rsp_rdata, 32'hFFFF8001);
        checkOutput("lh_rd", rsp_rd, 5'd9);
        req_valid   = 1'b0;
        dmem_rvalid = 1'b0;
        tick();
        checkOutput("lh_single_rsp_a", rsp_valid, 0);
        checkOutput("lh_idle_ready", req_ready, 1);
        tick();
        checkOutput("lh_single_rsp_b", rsp_valid, 0);

        // Reserved op completes without touching memory
        applyStimulus(3'b111, 32'h104, 32'h55, 5'd1);
        tick();
        req_valid = 1'b0;
        checkOutput("rsvd_rsp_valid", rsp_valid, 1);
        checkOutput("rsvd_rdata", rsp_rdata, 0);
        checkOutput("rsvd_mis", rsp_misaligned, 0);
        checkOutput("rsvd_no_req", dmem_req, 0);
        tick();
        checkOutput("rsvd_idle_ready", req_ready, 1);

        // Reset asserted in WAIT, late rvalid after release ignored
        applyStimulus(OP_LW, 32'h300, 32'h0, 5'd2);
        dmem_gnt = 1'b1;
        tick();
        req_valid = 1'b0;
        checkOutput("rw_req", dmem_req, 1);
        tick();
        dmem_gnt = 1'b0;
        #1 reset = 1'b0;
        #1;
        checkOutput("rw_async_ready", req_ready, 1);
        checkOutput("rw_async_req", dmem_req, 0);
        checkOutput("rw_async_addr", dmem_addr, 0);
        checkOutput("rw_async_rsp", rsp_valid, 0);
        tick();
        reset       = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hFFFFFFFF;
        tick();
        checkOutput("rw_late_rvalid_a", rsp_valid, 0);
        checkOutput("rw_late_ready", req_ready, 1);
        dmem_rvalid = 1'b0;
        tick();
        checkOutput("rw_late_rvalid_b", rsp_valid, 0);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: DATA_WIDTH, 32, data and address width; only 32 is supported.
REQ-002 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-low reset.
REQ-004 Port: req_valid  in  1  EX stage presents a memory operation.
REQ-005 Port: req_ready  out  1  unit accepts a request this cycle; high only in IDLE.
REQ-006 Port: mem_op  in  3  operation, type mem_op_e: LW, LH, LB, LBU, SW, SH, SB; code 3'b111 is reserved.
REQ-007 Port: addr  in  32  byte address; this is the ALUResult of the ADD.
REQ-008 Port: wdata  in  32  store data (rs2).
REQ-009 Port: rd_in  in  5  load destination register.
REQ-010 Port: rsp_valid  out  1  one-cycle completion pulse.
REQ-011 Port: rsp_rdata  out  32  extended load data; 0 for stores.
REQ-012 Port: rsp_rd  out  5  captured rd_in.
REQ-013 Port: rsp_misaligned  out  1  the access was suppressed as misaligned.
REQ-014 Port: dmem_req  out  1  data memory request.
REQ-015 Port: dmem_we  out  1  write enable.
REQ-016 Port: dmem_be  out  4  byte enables.
REQ-017 Port: dmem_addr  out  32  word-aligned address, addr[1:0] forced to 0.
REQ-018 Port: dmem_wdata  out  32  lane-replicated store data.
REQ-019 Port: dmem_gnt  in  1  memory accepts the current request.
REQ-020 Port: dmem_rvalid  in  1  load data valid.
REQ-021 Port: dmem_rdata  in  32  load data word.

Function
REQ-022 Handshake: a request is accepted when req_valid and req_ready are both high. The unit registers mem_op, addr, wdata and rd_in on acceptance.
REQ-023 FSM states and transitions:
- IDLE -> REQ on accept.
- IDLE -> RESP on accept of a misaligned or reserved op; no memory access is made.
- REQ: dmem_req is held high with stable outputs until dmem_gnt.
- REQ -> WAIT on dmem_gnt for a load.
- REQ -> RESP on dmem_gnt for a store.
- WAIT -> RESP on dmem_rvalid.
- RESP -> IDLE unconditionally.
REQ-024 Latency: accept at cycle N gives dmem_req at N+1. With an immediate grant, a store completes with rsp_valid at N+2. A load with rvalid at N+2 completes with rsp_valid at N+3.
REQ-025 Byte enables:
- LW/SW: dmem_be=4'b1111.
- LH/SH: dmem_be=4'b0011 or 4'b1100, selected by addr[1].
- LB/LBU/SB: dmem_be=1<<addr[1:0].
- dmem_we is 1 only for stores.
REQ-026 Store data: SB replicates wdata[7:0] into all four lanes. SH replicates wdata[15:0] into both halves. SW passes wdata unchanged.
REQ-027 Load data: dmem_rdata is captured on dmem_rvalid. The lane is selected by the registered addr[1:0]. LB/LH sign-extend; LBU zero-extends; LW passes the word unchanged.
REQ-028 dmem_rvalid outside WAIT is ignored. dmem_gnt outside REQ is ignored.
REQ-029 req_valid while busy is ignored and the in-flight request is unaffected; the upstream stage stalls on req_ready=0.
REQ-030 Reserved op: the unit completes in RESP with rsp_rdata=0, rsp_misaligned=0 and no dmem activity.
REQ-031 rsp_rdata, rsp_rd and rsp_misaligned are valid only while rsp_valid is high.

Reset
REQ-032 Asserting reset forces IDLE asynchronously, including mid-transaction. All outputs go to 0 immediately, except req_ready, which is 1.
REQ-033 A transaction in flight at reset is abandoned; a late dmem_rvalid after deassertion is ignored.

Configuration
REQ-034 Macro LSU_MISALIGN_TRAP_EN:
- Defined: LW/SW with addr[1:0]!=0, or LH/SH with addr[0]=1, skip dmem and complete with rsp_misaligned=1 and rsp_rdata=0.
- Undefined: low address bits are truncated to natural alignment (addr[1:0] treated as 0 for word ops, addr[0] as 0 for half ops), the access proceeds, and rsp_misaligned is tied to 0.

Structure
REQ-035 Package lsu_pkg SHALL hold mem_op_e, the FSM state enum lsu_state_e, and the byte-enable constants.
REQ-036 Load lane selection and extension SHALL be a combinational sub-module named load_extend.

Verification
REQ-037 SW addr=0x100, wdata=0xDEADBEEF, gnt immediate -> dmem_be=1111, dmem_addr=0x100, rsp_valid at N+2.
REQ-038 LB addr=0x103, rdata=0x80FF_1234 -> rsp_rdata=0xFFFFFF80. The same access with LBU -> 0x00000080.
REQ-039 SH addr=0x102, wdata=0x0000ABCD -> dmem_be=1100, dmem_wdata=0xABCDABCD.
REQ-040 LW addr=0x101 with the macro defined -> no dmem_req, rsp_misaligned=1, rsp_valid at N+1. Without the macro -> dmem_addr=0x100, access performed.
REQ-041 LH with gnt delayed 3 cycles and req_valid held high -> dmem_req stays high and stable, req_ready stays 0, exactly one response.
REQ-042 Reset asserted in WAIT, then rvalid after release -> outputs 0 immediately, IDLE, no rsp_valid.
